asp_irq_ctrl: RTL and testbench

ASP_IRQ_CTRL -- requirements
Module: asp_irq_ctrl

---
 rtl/ofs_asp_pkg.sv | 35 +++
 rtl/asp_irq_rr_arb.sv | 37 +++
 rtl/asp_irq_ctrl.sv | 158 +++++++++++++++
 tb/tb_asp_irq_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_asp_pkg.sv
// Shared constants for the ASP interrupt controller: source line map,
// CSR word indices, PARAMS field layout and controller FSM states.
package ofs_asp_pkg;

    localparam int ASP_NUM_INTERRUPT_LINES = 4;
    localparam int ASP_DMA_0_IRQ_BIT       = 0;
    localparam int ASP_KERNEL_IRQ_BIT      = 1;
    localparam int ASP_DMA_1_IRQ_BIT       = 2;

    localparam logic [15:0] ASP_USED_IRQ_MASK = 16'((1 << ASP_DMA_0_IRQ_BIT) |
                                                    (1 << ASP_KERNEL_IRQ_BIT) |
                                                    (1 << ASP_DMA_1_IRQ_BIT));
    localparam logic [15:0] ASP_EDGE_IRQ_MASK = 16'h0005;

    localparam logic [2:0] CSR_PENDING    = 3'd0;
    localparam logic [2:0] CSR_ENABLE     = 3'd1;
    localparam logic [2:0] CSR_CLEAR      = 3'd2;
    localparam logic [2:0] CSR_FORCE      = 3'd3;
    localparam logic [2:0] CSR_SENT_COUNT = 3'd4;
    localparam logic [2:0] CSR_PARAMS     = 3'd5;

    localparam int PARAMS_NUM_IRQ_LSB   = 0;
    localparam int PARAMS_USED_MASK_LSB = 8;
    localparam int PARAMS_EDGE_MASK_LSB = 24;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_REQ  = 1'b1
    } irq_state_e;

    function automatic int irq_id_width(input int num_lines);
        return (num_lines > 1) ? $clog2(num_lines) : 1;
    endfunction

endpackage

// File: rtl/asp_irq_rr_arb.sv
// Combinational round-robin arbiter: grants the first requesting line
// strictly after last_grant, wrapping around to line 0.
module asp_irq_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves one unassigned (no latch).
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt       = '0;
        // Wrapped lines (at or below the pointer) first; lines above it then override.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i <= int'(last_grant))) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(last_grant))) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = gnt_valid && (gnt_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt controller: per-line pending/enable/sent state behind a small
// CSR block, feeding a valid/ready interrupt channel through a round-robin FSM.
module asp_irq_ctrl
    import ofs_asp_pkg::*;
#(
    parameter int                 NUM_IRQ        = ASP_NUM_INTERRUPT_LINES,
    parameter logic [NUM_IRQ-1:0] USED_MASK      = NUM_IRQ'(ASP_USED_IRQ_MASK),
    parameter logic [NUM_IRQ-1:0] EDGE_MASK      = NUM_IRQ'(ASP_EDGE_IRQ_MASK),
    parameter int                 CSR_DATA_WIDTH = 64,
    localparam int                ID_W           = irq_id_width(NUM_IRQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_IRQ-1:0]        irq_in,
    input  logic                      csr_write,
    input  logic                      csr_read,
    input  logic [2:0]                csr_address,
    input  logic [CSR_DATA_WIDTH-1:0] csr_writedata,
    output logic [CSR_DATA_WIDTH-1:0] csr_readdata,
    output logic                      csr_readdatavalid,
    output logic                      irq_valid,
    output logic [ID_W-1:0]           irq_id,
    input  logic                      irq_ready
);

    localparam logic [63:0] PARAMS_WORD =
        (64'(8'(NUM_IRQ))    << PARAMS_NUM_IRQ_LSB)   |
        (64'(16'(USED_MASK)) << PARAMS_USED_MASK_LSB) |
        (64'(16'(EDGE_MASK)) << PARAMS_EDGE_MASK_LSB);

    irq_state_e         state;
    logic [NUM_IRQ-1:0] irq_in_q;
    logic               init_done;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] sent;
    logic [31:0]        sent_count;
    logic [ID_W-1:0]    last_ptr;
    logic [NUM_IRQ-1:0] grant_mask_q;

    logic [NUM_IRQ-1:0] wdata_irq;
    logic               clear_wr;
    logic               force_wr;
    logic               accept;
    logic [NUM_IRQ-1:0] edge_evt;
    logic [NUM_IRQ-1:0] irq_evt;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] sent_nxt;
    logic [NUM_IRQ-1:0] candidate;
    logic [NUM_IRQ-1:0] gnt_mask;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_valid;
    logic [63:0]        rd_word;
    logic               unused_bits;

    assign wdata_irq = csr_writedata[NUM_IRQ-1:0];
    assign clear_wr  = csr_write && (csr_address == CSR_CLEAR);
    assign force_wr  = csr_write && (csr_address == CSR_FORCE);
    assign accept    = irq_valid && irq_ready;
    assign candidate = pending & enable & ~sent;

    // Bits of the write bus and of the edge history that this configuration never looks at.
    assign unused_bits = ^{csr_writedata, irq_in_q, irq_in, edge_evt};

    always_comb begin
        // Edge detection is suppressed on the first cycle out of reset so a line already high is not an edge.
        edge_evt    = irq_in & ~irq_in_q & {NUM_IRQ{init_done}};
        irq_evt     = USED_MASK & ((EDGE_MASK & edge_evt) | (~EDGE_MASK & irq_in));
        // Set terms are OR-ed in after the clear, so a same-cycle event or FORCE wins.
        pending_nxt = (pending & ~(clear_wr ? wdata_irq : '0))
                    | irq_evt
                    | (force_wr ? (wdata_irq & USED_MASK) : '0);
        sent_nxt    = (sent | (accept ? (grant_mask_q & pending) : '0)) & pending_nxt;
    end

    always_comb begin
        rd_word = '0;
        case (csr_address)
            CSR_PENDING:    rd_word = 64'(pending);
            CSR_ENABLE:     rd_word = 64'(enable);
            CSR_SENT_COUNT: rd_word = 64'(sent_count);
            CSR_PARAMS:     rd_word = PARAMS_WORD;
            default:        rd_word = '0;
        endcase
    end

    asp_irq_rr_arb #(
        .NUM_REQ (NUM_IRQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req        (candidate),
        .last_grant (last_ptr),
        .gnt        (gnt_mask),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_in_q          <= '0;
            init_done         <= 1'b0;
            pending           <= '0;
            enable            <= '0;
            sent              <= '0;
            csr_readdata      <= '0;
            csr_readdatavalid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            irq_in_q          <= irq_in;
            init_done         <= 1'b1;
            pending           <= pending_nxt;
            sent              <= sent_nxt;
            csr_readdatavalid <= csr_read;
            csr_readdata      <= csr_read ? CSR_DATA_WIDTH'(rd_word) : '0;
            if (csr_write && (csr_address == CSR_ENABLE)) begin
                enable <= wdata_irq;
            end
        end
    end

    // Once latched, a request is held until accepted regardless of later ENABLE/PENDING changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IRQ_IDLE;
            irq_valid    <= 1'b0;
            irq_id       <= '0;
            grant_mask_q <= '0;
            last_ptr     <= ID_W'(NUM_IRQ - 1);
            sent_count   <= '0;
        end else begin
            case (state)
                IRQ_IDLE: begin
                    if (gnt_valid) begin
                        state        <= IRQ_REQ;
                        irq_valid    <= 1'b1;
                        irq_id       <= gnt_idx;
                        grant_mask_q <= gnt_mask;
                        last_ptr     <= gnt_idx;
                    end
                end
                IRQ_REQ: begin
                    if (irq_ready) begin
                        state     <= IRQ_IDLE;
                        irq_valid <= 1'b0;
                        if (sent_count != '1) begin
                            sent_count <= sent_count + 32'd1;
                        end
                    end
                end
                default: begin
                    state     <= IRQ_IDLE;
                    irq_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Self-checking bench for asp_irq_ctrl: expected interrupt ids are queued as
// stimulus is applied and popped when the interrupt channel handshakes.
module tb_asp_irq_ctrl;
    import ofs_asp_pkg::*;

    localparam int          DW         = 64;
    localparam logic [63:0] EXP_PARAMS = 64'h0000_0000_0500_0704;

    logic          clk;
    logic          reset_n;
    logic [3:0]    irq_in;
    logic          csr_write;
    logic          csr_read;
    logic [2:0]    csr_address;
    logic [DW-1:0] csr_writedata;
    logic [DW-1:0] csr_readdata;
    logic          csr_readdatavalid;
    logic          irq_valid;
    logic [1:0]    irq_id;
    logic          irq_ready;

    int         checks = 0;
    int         errors = 0;
    int         exp_count = 0;
    logic [1:0] exp_q[$];

    asp_irq_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .irq_in            (irq_in),
        .csr_write         (csr_write),
        .csr_read          (csr_read),
        .csr_address       (csr_address),
        .csr_writedata     (csr_writedata),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .irq_valid         (irq_valid),
        .irq_id            (irq_id),
        .irq_ready         (irq_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Pops one expected id per accepted request (sampled at negedge, before the accepting edge).
    task automatic scoreboard_monitor();
        logic [1:0] exp_id;
        forever begin
            @(negedge clk);
            if (reset_n && irq_valid && irq_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_irq: got id=%0d, expected no request", irq_id);
                end else begin
                    exp_id = exp_q.pop_front();
                    if (irq_id !== exp_id) begin
                        errors++;
                        $display("FAIL irq_id: got %0d expected %0d", irq_id, exp_id);
                    end
                end
            end
        end
    endtask

    task automatic do_reset(input logic [3:0] hold_in);
        reset_n       = 1'b0;
        irq_in        = hold_in;
        csr_write     = 1'b0;
        csr_read      = 1'b0;
        csr_address   = '0;
        csr_writedata = '0;
        irq_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_q.delete();
        exp_count = 0;
    endtask

    task automatic csr_wr(input logic [2:0] addr, input logic [63:0] data);
        @(posedge clk);
        #1 csr_write = 1'b1;
        csr_address   = addr;
        csr_writedata = data;
        @(posedge clk);
        #1 csr_write = 1'b0;
        csr_writedata = '0;
    endtask

    task automatic csr_rd(input logic [2:0] addr, output logic [63:0] data);
        @(posedge clk);
        #1 csr_read = 1'b1;
        csr_address = addr;
        @(posedge clk);
        #1 csr_read = 1'b0;
        checks++;
        if (csr_readdatavalid !== 1'b1) begin
            errors++;
            $display("FAIL rd_valid addr=%0d: got %b expected 1", addr, csr_readdatavalid);
        end
        data = csr_readdata;
        @(posedge clk);
        #1;
        checks++;
        if (csr_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_pulse addr=%0d: got %b expected 0", addr, csr_readdatavalid);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && !irq_valid) break;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: %0d ids outstanding, irq_valid=%b", exp_q.size(), irq_valid);
        end
    endtask

    task automatic test_reset();
        logic [63:0] d;
        logic [63:0] exp;
        do_reset(4'b0000);
        checks++;
        if (irq_valid !== 1'b0 || csr_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: irq_valid=%b rdvalid=%b expected 0 0", irq_valid, csr_readdatavalid);
        end
        for (int a = 0; a < 8; a++) begin
            exp = (a == 5) ? EXP_PARAMS : 64'd0;
            csr_rd(3'(a), d);
            checks++;
            if (d !== exp) begin
                errors++;
                $display("FAIL reset_csr[%0d]: got 0x%0h expected 0x%0h", a, d, exp);
            end
        end
    endtask

    task automatic test_reset_release();
        logic [63:0] d;
        do_reset(4'b0011);
        repeat (2) @(posedge clk);
        csr_rd(CSR_PENDING, d);
        checks++;
        if (d !== 64'h2) begin
            errors++;
            $display("FAIL release_pending: got 0x%0h expected 0x2", d);
        end
        irq_in = 4'b0000;
        csr_wr(CSR_CLEAR, 64'hF);
        csr_rd(CSR_PENDING, d);
        checks++;
        if (d !== 64'h0) begin
            errors++;
            $display("FAIL release_clear: got 0x%0h expected 0x0", d);
        end
    endtask

    task automatic test_single_pulse();
        logic [63:0] d;
        do_reset(4'b0000);
        csr_wr(CSR_ENABLE, 64'h7);
        irq_ready = 1'b1;
        exp_q.push_back(2'd0);
        exp_count++;
        @(posedge clk);
        #1 irq_in[0] = 1'b1;
        @(posedge clk);
        #1 irq_in[0] = 1'b0;
        checks++;
        if (irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: irq_valid=%b expected 0", irq_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin
            errors++;
            $display("FAIL latency: irq_valid=%b id=%0d expected 1 id=0", irq_valid, irq_id);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL one_beat: irq_valid=%b expected 0", irq_valid);
        end
        wait_drain(10);
        csr_rd(CSR_SENT_COUNT, d);
        checks++;
        if (d !== 64'(exp_count)) begin
            errors++;
            $display("FAIL pulse_count: got %0d expected %0d", d, exp_count);
        end
        csr_rd(CSR_PENDING, d);
        checks++;
        if (d !== 64'h1) begin
            errors++;
            $display("FAIL pulse_pending: got 0x%0h expected 0x1", d);
        end
    endtask

    task automatic test_two_lines();
        logic [63:0] d;
        do_reset(4'b0000);
        csr_wr(CSR_ENABLE, 64'h7);
        irq_ready = 1'b0;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        exp_count += 2;
        @(posedge clk);
        #1 irq_in = 4'b0101;
        @(posedge clk);
        #1 irq_in = 4'b0000;
        for (int i = 0; i < 10 && !irq_valid; i++) @(negedge clk);
        checks++;
        if (irq_valid !== 1'b1) begin
            errors++;
            $display("FAIL two_valid_timeout: irq_valid=%b expected 1", irq_valid);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin
                errors++;
                $display("FAIL hold_stable: irq_valid=%b id=%0d expected 1 id=0", irq_valid, irq_id);
            end
        end
        @(posedge clk);
        #1 irq_ready = 1'b1;
        wait_drain(20);
        csr_rd(CSR_SENT_COUNT, d);
        checks++;
        if (d !== 64'(exp_count)) begin
            errors++;
            $display("FAIL two_count: got %0d expected %0d", d, exp_count);
        end
    endtask

    task automatic test_level();
        logic [63:0] d;
        do_reset(4'b0000);
        csr_wr(CSR_ENABLE, 64'h7);
        irq_ready = 1'b1;
        exp_q.push_back(2'd1);
        exp_count++;
        @(posedge clk);
        #1 irq_in[1] = 1'b1;
        wait_drain(20);
        csr_wr(CSR_CLEAR, 64'h2);
        csr_rd(CSR_PENDING, d);
        checks++;
        if (d !== 64'h2) begin
            errors++;
            $display("FAIL level_reassert: got 0x%0h expected 0x2", d);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL level_no_repeat: irq_valid=%b expected 0", irq_valid);
        end
        irq_in[1] = 1'b0;
        csr_wr(CSR_CLEAR, 64'h2);
        csr_rd(CSR_PENDING, d);
        checks++;
        if (d !== 64'h0) begin
            errors++;
            $display("FAIL level_cleared: got 0x%0h expected 0x0", d);
        end
        exp_q.push_back(2'd1);
        exp_count++;
        @(posedge clk);
        #1 irq_in[1] = 1'b1;
        wait_drain(20);
        csr_rd(CSR_SENT_COUNT, d);
        checks++;
        if (d !== 64'(exp_count)) begin
            errors++;
            $display("FAIL level_count: got %0d expected %0d", d, exp_count);
        end
        irq_in = 4'b0000;
        csr_wr(CSR_CLEAR, 64'h2);
    endtask

    task automatic test_force_unused();
        logic [63:0] d;
        do_reset(4'b0000);
        irq_ready = 1'b1;
        csr_wr(CSR_FORCE, 64'h8);
        csr_rd(CSR_PENDING, d);
        checks++;
        if (d !== 64'h0 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL force_unused: pending=0x%0h irq_valid=%b expected 0x0 0", d, irq_valid);
        end
        csr_wr(CSR_FORCE, 64'h1);
        csr_rd(CSR_PENDING, d);
        checks++;
        if (d !== 64'h1 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL force_disabled: pending=0x%0h irq_valid=%b expected 0x1 0", d, irq_valid);
        end
        exp_q.push_back(2'd0);
        exp_count++;
        csr_wr(CSR_ENABLE, 64'h1);
        wait_drain(20);
        csr_rd(CSR_SENT_COUNT, d);
        checks++;
        if (d !== 64'(exp_count)) begin
            errors++;
            $display("FAIL force_count: got %0d expected %0d", d, exp_count);
        end
    endtask

    task automatic test_edge_vs_clear();
        logic [63:0] d;
        do_reset(4'b0000);
        csr_wr(CSR_FORCE, 64'h1);
        @(posedge clk);
        #1 irq_in[0] = 1'b1;
        csr_write     = 1'b1;
        csr_address   = CSR_CLEAR;
        csr_writedata = 64'h1;
        @(posedge clk);
        #1 csr_write = 1'b0;
        csr_writedata = '0;
        csr_rd(CSR_PENDING, d);
        checks++;
        if (d !== 64'h1) begin
            errors++;
            $display("FAIL set_wins: got 0x%0h expected 0x1", d);
        end
        csr_wr(CSR_CLEAR, 64'h1);
        csr_rd(CSR_PENDING, d);
        checks++;
        if (d !== 64'h0) begin
            errors++;
            $display("FAIL edge_held_clear: got 0x%0h expected 0x0", d);
        end
        irq_in = 4'b0000;
    endtask

    task automatic test_reset_mid_req();
        logic [63:0] d;
        logic [63:0] exp;
        do_reset(4'b0000);
        csr_wr(CSR_ENABLE, 64'h1);
        csr_wr(CSR_FORCE, 64'h1);
        for (int i = 0; i < 10 && !irq_valid; i++) @(negedge clk);
        checks++;
        if (irq_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreq_valid_timeout: irq_valid=%b expected 1", irq_valid);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_drop: irq_valid=%b expected 0", irq_valid);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_q.delete();
        for (int a = 0; a < 8; a++) begin
            exp = (a == 5) ? EXP_PARAMS : 64'd0;
            csr_rd(3'(a), d);
            checks++;
            if (d !== exp) begin
                errors++;
                $display("FAIL midreq_csr[%0d]: got 0x%0h expected 0x%0h", a, d, exp);
            end
        end
    endtask

    initial begin
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_reset_release();
        test_single_pulse();
        test_two_lines();
        test_level();
        test_force_unused();
        test_edge_vs_clear();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
